// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Purpose : Shared definitions for the sequential arithmetic blocks. It holds
//           the FSM state type and a helper that sizes bit counters.
// Contents:
//   state_t        - IDLE / RUN / DONE sequencing states
//   cnt_width(w)   - counter width able to index w bit positions (min 1)
// ---------------------------------------------------------------------------
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A 1-bit operand still needs a 1-bit counter, so clamp at 1.
   function automatic int cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/fulladder1.sv
// ---------------------------------------------------------------------------
// fulladder1
// Purpose : Single-bit full adder cell, the bit-slice used by serial_adder.
// Ports   :
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
// ---------------------------------------------------------------------------
module fulladder1 (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
// Purpose : Bit-serial unsigned adder. Operands are taken over a valid/ready
//           handshake, added LSB-first one bit per clock through a single
//           fulladder1 cell with a registered carry, and the WIDTH-bit sum and
//           carry-out are returned over a valid/ready handshake.
// Parameters:
//   WIDTH      - operand/sum width in bits (>= 1)
// Ports   :
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   in_valid   - a/b/cin valid
//   in_ready   - block can accept operands (IDLE)
//   a, b       - operands
//   cin        - carry into bit 0
//   out_valid  - sum/cout valid (DONE)
//   out_ready  - consumer accepts result
//   sum        - low WIDTH bits of a+b+cin
//   cout       - carry out of bit WIDTH-1
//   busy       - high while adding (RUN)
//   ovf        - two's-complement overflow, only when SERIAL_ADDER_OVF_EN
//                is defined
// Build option:
//   SERIAL_ADDER_OVF_EN - adds the ovf output and its capture register
// ---------------------------------------------------------------------------
module serial_adder
   import arith_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] s_msb;

`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_r;
`endif

   // The one datapath slice: it always looks at the current LSBs and the
   // registered carry, so its outputs are only meaningful while in RUN.
   fulladder1 u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // New sum bit positioned at the MSB. Building it this way keeps the
   // right-shift insert legal even when WIDTH is 1.
   always_comb begin
      s_msb            = '0;
      s_msb[WIDTH-1]   = fa_s;
   end

   // Sequencer and datapath registers. Handshake outputs are registered and
   // updated together with the state so they always agree with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum_sh    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_r     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= a;
                  b_sh     <= b;
                  carry    <= cin;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            RUN: begin
               sum_sh <= (sum_sh >> 1) | s_msb;
               carry  <= fa_cout;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
`ifdef SERIAL_ADDER_OVF_EN
                  // On the last bit the registered carry is the carry into
                  // the MSB, and fa_cout is the final carry-out.
                  ovf_r     <= carry ^ fa_cout;
`endif
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Results come straight from registers. The carry register already holds
   // the final carry-out once RUN has finished.
   assign sum  = sum_sh;
   assign cout = carry;

`ifdef SERIAL_ADDER_OVF_EN
   assign ovf = ovf_r;
`endif

endmodule
